// File: rtl/vx_rt_csr_pkg.sv
// Shared definitions for the ray-tracing CSR block: address map, FSM encoding,
// and helpers for locating the CMD/STATUS words behind the ray words.
package vx_rt_csr_pkg;

    localparam int VX_CSR_ADDR_BITS = 12;
    localparam int RT_RAY_REGS      = 8;   // org xyz, dir xyz, tmin, tmax
    localparam int RT_CSR_CMD       = RT_RAY_REGS;
    localparam int RT_CSR_STATUS    = RT_RAY_REGS + 1;

    // First and last (inclusive) address of the RT CSR window.
    localparam logic [VX_CSR_ADDR_BITS-1:0] VX_CSR_RT_BEGIN = 12'hBC0;
    localparam logic [VX_CSR_ADDR_BITS-1:0] VX_CSR_RT_END   = VX_CSR_RT_BEGIN + 12'(RT_CSR_STATUS);

    typedef enum logic [1:0] {
        RT_IDLE    = 2'd0,
        RT_PENDING = 2'd1,
        RT_BUSY    = 2'd2
    } rt_state_e;

    // Request header carried alongside the ray payload.
    typedef struct packed {
        logic [1:0] wid;
        logic [3:0] tmask;
    } rt_req_hdr_t;

    // Offsets follow the ray words, so they move with the ray word count.
    function automatic int rt_cmd_off(input int ray_regs);
        return ray_regs;
    endfunction

    function automatic int rt_status_off(input int ray_regs);
        return ray_regs + 1;
    endfunction

endpackage

// File: rtl/vx_rt_csr_rr_arbiter.sv
// Round-robin arbiter. Once a grant is shown without unlock it is locked and
// held until unlock, then priority rotates to the requester after the winner.
module vx_rt_csr_rr_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQS-1:0]     requests,
    input  logic                    unlock,
    output logic                    grant_valid,
    output logic [LOG_NUM_REQS-1:0] grant_index
);

    logic [LOG_NUM_REQS-1:0] prio_q;
    logic [LOG_NUM_REQS-1:0] locked_idx_q;
    logic                    locked_q;
    logic [LOG_NUM_REQS-1:0] hi_idx;
    logic [LOG_NUM_REQS-1:0] lo_idx;
    logic                    hi_valid;
    logic                    lo_valid;

    // Lowest requester at or above the priority pointer, else lowest overall.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_valid = 1'b0;
        lo_valid = 1'b0;
        for (int j = NUM_REQS - 1; j >= 0; j--) begin
            if (requests[j]) begin
                lo_idx   = LOG_NUM_REQS'(j);
                lo_valid = 1'b1;
                if (LOG_NUM_REQS'(j) >= prio_q) begin
                    hi_idx   = LOG_NUM_REQS'(j);
                    hi_valid = 1'b1;
                end
            end
        end
    end

    assign grant_valid = locked_q | lo_valid;
    assign grant_index = locked_q ? locked_idx_q : (hi_valid ? hi_idx : lo_idx);

    // Lock an unaccepted grant; on acceptance release and rotate past the winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q       <= '0;
            locked_q     <= 1'b0;
            locked_idx_q <= '0;
        end else if (grant_valid) begin
            if (unlock) begin
                locked_q <= 1'b0;
                prio_q   <= (grant_index == LOG_NUM_REQS'(NUM_REQS - 1)) ? '0
                                                                         : grant_index + LOG_NUM_REQS'(1);
            end else begin
                locked_q     <= 1'b1;
                locked_idx_q <= grant_index;
            end
        end
    end

endmodule

// File: rtl/vx_rt_csr.sv
// Ray-tracing CSR block: per-warp ray storage, CMD/STATUS CSRs, per-warp
// IDLE/PENDING/BUSY tracking and a round-robin request port to the RT unit.
// rt_req_rays packs word r of lane l at bits [(r*NUM_LANES + l)*XLEN +: XLEN].
// Request handshake: a request transfers on a clock edge where rt_req_valid
// and rt_req_ready are both high; while valid is high and ready low, wid,
// tmask and rays are held unchanged.
module vx_rt_csr
    import vx_rt_csr_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int NUM_LANES = 4,
    parameter int XLEN      = 32,
    parameter int RAY_REGS  = RT_RAY_REGS,
    parameter int NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               read_enable,
    input  logic [NW_WIDTH-1:0]                read_wid,
    input  logic [VX_CSR_ADDR_BITS-1:0]        read_addr,
    output logic [NUM_LANES*XLEN-1:0]          read_data,
    input  logic                               write_enable,
    input  logic [NW_WIDTH-1:0]                write_wid,
    input  logic [NUM_LANES-1:0]               write_tmask,
    input  logic [VX_CSR_ADDR_BITS-1:0]        write_addr,
    input  logic [NUM_LANES*XLEN-1:0]          write_data,
    output logic                               rt_req_valid,
    input  logic                               rt_req_ready,
    output logic [NW_WIDTH-1:0]                rt_req_wid,
    output logic [NUM_LANES-1:0]               rt_req_tmask,
    output logic [NUM_LANES*RAY_REGS*XLEN-1:0] rt_req_rays,
    input  logic                               rt_rsp_valid,
    input  logic [NW_WIDTH-1:0]                rt_rsp_wid,
    output logic [2*NUM_WARPS-1:0]             state_dbg
);

    localparam int AB = VX_CSR_ADDR_BITS;
    localparam logic [AB-1:0] CMD_OFF    = AB'(rt_cmd_off(RAY_REGS));
    localparam logic [AB-1:0] STATUS_OFF = AB'(rt_status_off(RAY_REGS));

    rt_state_e            state_q [NUM_WARPS];
    rt_state_e            state_d [NUM_WARPS];
    logic [NUM_LANES-1:0] tmask_q [NUM_WARPS];
    logic [XLEN-1:0]      rays_q  [NUM_WARPS][RAY_REGS][NUM_LANES];

    logic [AB-1:0]        rd_off;
    logic [AB-1:0]        wr_off;
    logic                 ray_wr;
    logic                 cmd_wr;
    logic                 req_fire;
    logic [NUM_WARPS-1:0] pending;
    logic [NW_WIDTH-1:0]  grant_idx;

    // Addresses below the window wrap to large offsets and decode as out of range.
    assign rd_off   = read_addr - VX_CSR_RT_BEGIN;
    assign wr_off   = write_addr - VX_CSR_RT_BEGIN;
    assign ray_wr   = write_enable && (wr_off < CMD_OFF);
    assign cmd_wr   = write_enable && (wr_off == CMD_OFF) && (|write_tmask);
    assign req_fire = rt_req_valid && rt_req_ready;

    // Pending vector feeding the arbiter and the state debug view.
    always_comb begin
        pending   = '0;
        state_dbg = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending[w]         = (state_q[w] == RT_PENDING);
            state_dbg[2*w +: 2] = state_q[w];
        end
    end

    vx_rt_csr_rr_arbiter #(
        .NUM_REQS     (NUM_WARPS),
        .LOG_NUM_REQS (NW_WIDTH)
    ) arbiter (
        .clk         (clk),
        .reset       (reset),
        .requests    (pending),
        .unlock      (rt_req_ready),
        .grant_valid (rt_req_valid),
        .grant_index (grant_idx)
    );

    // Per-warp next state; a CMD only starts an IDLE warp, so a CMD racing a
    // completion on a BUSY warp is dropped and the warp returns to IDLE.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            state_d[w] = state_q[w];
            case (state_q[w])
                RT_IDLE:    if (cmd_wr && write_wid == NW_WIDTH'(w)) state_d[w] = RT_PENDING;
                RT_PENDING: if (req_fire && grant_idx == NW_WIDTH'(w)) state_d[w] = RT_BUSY;
                RT_BUSY:    if (rt_rsp_valid && rt_rsp_wid == NW_WIDTH'(w)) state_d[w] = RT_IDLE;
                default:    state_d[w] = RT_IDLE;
            endcase
        end
    end

    // Per-warp state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) state_q[w] <= RT_IDLE;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) state_q[w] <= state_d[w];
        end
    end

    // Ray and tmask storage; only IDLE warps accept writes, which keeps the
    // payload of a PENDING warp frozen until it is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                tmask_q[w] <= '0;
                for (int r = 0; r < RAY_REGS; r++)
                    for (int l = 0; l < NUM_LANES; l++) rays_q[w][r][l] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (write_wid == NW_WIDTH'(w) && state_q[w] == RT_IDLE) begin
                    if (cmd_wr) tmask_q[w] <= write_tmask;
                    for (int r = 0; r < RAY_REGS; r++)
                        for (int l = 0; l < NUM_LANES; l++)
                            if (ray_wr && wr_off == AB'(r) && write_tmask[l])
                                rays_q[w][r][l] <= write_data[l*XLEN +: XLEN];
                end
            end
        end
    end

    // Request payload for the granted warp.
    always_comb begin
        rt_req_wid   = grant_idx;
        rt_req_tmask = '0;
        rt_req_rays  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (grant_idx == NW_WIDTH'(w)) begin
                rt_req_tmask = tmask_q[w];
                for (int r = 0; r < RAY_REGS; r++)
                    for (int l = 0; l < NUM_LANES; l++)
                        rt_req_rays[(r*NUM_LANES + l)*XLEN +: XLEN] = rays_q[w][r][l];
            end
        end
    end

    // Combinational CSR read of pre-write state; CMD and unmapped offsets read zero.
    always_comb begin
        read_data = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (read_enable && read_wid == NW_WIDTH'(w)) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (rd_off == STATUS_OFF)
                        read_data[l*XLEN +: XLEN] = XLEN'(state_q[w] != RT_IDLE);
                    for (int r = 0; r < RAY_REGS; r++)
                        if (rd_off == AB'(r)) read_data[l*XLEN +: XLEN] = rays_q[w][r][l];
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_rt_csr.sv
// Directed bench for vx_rt_csr: a table of single-cycle CSR write/read
// vectors followed by hand-written request/response sequences.
module tb_vx_rt_csr;
    import vx_rt_csr_pkg::*;

    localparam int NL = 4;
    localparam int XL = 32;
    localparam int RR = 8;

    logic              clk;
    logic              reset;
    logic              read_enable;
    logic [1:0]        read_wid;
    logic [11:0]       read_addr;
    logic [NL*XL-1:0]  read_data;
    logic              write_enable;
    logic [1:0]        write_wid;
    logic [NL-1:0]     write_tmask;
    logic [11:0]       write_addr;
    logic [NL*XL-1:0]  write_data;
    logic              rt_req_valid;
    logic              rt_req_ready;
    logic [1:0]        rt_req_wid;
    logic [NL-1:0]     rt_req_tmask;
    logic [NL*RR*XL-1:0] rt_req_rays;
    logic              rt_rsp_valid;
    logic [1:0]        rt_rsp_wid;
    logic [7:0]        state_dbg;

    int total = 0;
    int bad   = 0;

    vx_rt_csr dut (
        .clk          (clk),
        .reset        (reset),
        .read_enable  (read_enable),
        .read_wid     (read_wid),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .write_enable (write_enable),
        .write_wid    (write_wid),
        .write_tmask  (write_tmask),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .rt_req_valid (rt_req_valid),
        .rt_req_ready (rt_req_ready),
        .rt_req_wid   (rt_req_wid),
        .rt_req_tmask (rt_req_tmask),
        .rt_req_rays  (rt_req_rays),
        .rt_rsp_valid (rt_rsp_valid),
        .rt_rsp_wid   (rt_rsp_wid),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic         we;
        logic [1:0]   wwid;
        logic [3:0]   wmask;
        logic [11:0]  waddr;
        logic [31:0]  wword;
        logic [1:0]   rwid;
        logic [11:0]  raddr;
        logic [127:0] exp_rd;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic we, input int wwid, input logic [3:0] wmask,
                                input int woff, input logic [31:0] wword,
                                input int rwid, input int roff, input logic [127:0] exp_rd);
        vec_t v;
        v.we     = we;
        v.wwid   = 2'(wwid);
        v.wmask  = wmask;
        v.waddr  = VX_CSR_RT_BEGIN + 12'(woff);
        v.wword  = wword;
        v.rwid   = 2'(rwid);
        v.raddr  = VX_CSR_RT_BEGIN + 12'(roff);
        v.exp_rd = exp_rd;
        return v;
    endfunction

    function automatic logic [127:0] all4(input logic [31:0] w);
        return {w, w, w, w};
    endfunction

    // scoreboard helpers
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rays(input string name, input logic [NL*RR*XL-1:0] exp);
        total++;
        if (rt_req_rays !== exp) begin
            bad++;
            for (int k = 0; k < NL*RR; k++) begin
                if (rt_req_rays[k*XL +: XL] !== exp[k*XL +: XL]) begin
                    $display("FAIL %s: word %0d got %h expected %h", name, k,
                             rt_req_rays[k*XL +: XL], exp[k*XL +: XL]);
                    break;
                end
            end
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic wr(input int wid, input logic [3:0] mask, input int off, input logic [31:0] word);
        write_enable = 1'b1;
        write_wid    = 2'(wid);
        write_tmask  = mask;
        write_addr   = VX_CSR_RT_BEGIN + 12'(off);
        write_data   = all4(word);
    endtask

    task automatic rd_chk(input string name, input int wid, input int off, input logic [127:0] exp);
        read_enable = 1'b1;
        read_wid    = 2'(wid);
        read_addr   = VX_CSR_RT_BEGIN + 12'(off);
        #1;
        chk(name, read_data, exp);
    endtask

    task automatic req_chk(input string name, input int wid, input logic [3:0] mask);
        chk({name, " valid"}, 128'(rt_req_valid), 128'(1));
        chk({name, " wid"}, 128'(rt_req_wid), 128'(wid));
        chk({name, " tmask"}, 128'(rt_req_tmask), 128'(mask));
    endtask

    localparam logic [127:0] ONE4 = {32'h1, 32'h1, 32'h1, 32'h1};
    logic [NL*RR*XL-1:0] exp_rays;

    initial begin
        reset        = 1'b1;
        read_enable  = 1'b1;
        read_wid     = '0;
        read_addr    = VX_CSR_RT_BEGIN;
        write_enable = 1'b0;
        write_wid    = '0;
        write_tmask  = '0;
        write_addr   = '0;
        write_data   = '0;
        rt_req_ready = 1'b0;
        rt_rsp_valid = 1'b0;
        rt_rsp_wid   = '0;

        // lane order in expected words: {lane3, lane2, lane1, lane0}
        vecs[0]  = mk(0, 0, 4'h0, 0, 32'h0, 1, 0, 128'h0);
        vecs[1]  = mk(1, 1, 4'h5, 0, 32'h3F800000, 1, 0, 128'h0);
        vecs[2]  = mk(0, 0, 4'h0, 0, 32'h0, 1, 0, {32'h0, 32'h3F800000, 32'h0, 32'h3F800000});
        vecs[3]  = mk(1, 1, 4'hA, 0, 32'hAAAA0001, 1, 9, 128'h0);
        vecs[4]  = mk(0, 0, 4'h0, 0, 32'h0, 1, 0, {32'hAAAA0001, 32'h3F800000, 32'hAAAA0001, 32'h3F800000});
        vecs[5]  = mk(1, 0, 4'hF, 7, 32'h11112222, 0, 7, 128'h0);
        vecs[6]  = mk(0, 0, 4'h0, 0, 32'h0, 0, 7, all4(32'h11112222));
        vecs[7]  = mk(0, 0, 4'h0, 0, 32'h0, 2, 0, 128'h0);
        vecs[8]  = mk(0, 0, 4'h0, 0, 32'h0, 0, 8, 128'h0);
        vecs[9]  = mk(1, 3, 4'hF, 10, 32'hDEADBEEF, 3, 10, 128'h0);
        vecs[10] = mk(1, 3, 4'h0, 6, 32'h77777777, 0, -1, 128'h0);
        vecs[11] = mk(0, 0, 4'h0, 0, 32'h0, 3, 2, 128'h0);
        vecs[12] = mk(1, 3, 4'h0, 8, 32'h0, 3, 6, 128'h0);
        vecs[13] = mk(0, 0, 4'h0, 0, 32'h0, 3, 9, 128'h0);
        vecs[14] = mk(1, 2, 4'h3, 1, 32'h0BAD0001, 1, 0, {32'hAAAA0001, 32'h3F800000, 32'hAAAA0001, 32'h3F800000});
        vecs[15] = mk(0, 0, 4'h0, 0, 32'h0, 2, 1, {32'h0, 32'h0, 32'h0BAD0001, 32'h0BAD0001});

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;

        // reset state
        chk("reset valid", 128'(rt_req_valid), 128'(0));
        for (int w = 0; w < 4; w++) rd_chk($sformatf("reset status w%0d", w), w, 9, 128'h0);
        rd_chk("reset ray", 2, 3, 128'h0);

        // table of single-cycle write/read vectors
        for (int i = 0; i < NV; i++) begin
            write_enable = vecs[i].we;
            write_wid    = vecs[i].wwid;
            write_tmask  = vecs[i].wmask;
            write_addr   = vecs[i].waddr;
            write_data   = all4(vecs[i].wword);
            read_enable  = 1'b1;
            read_wid     = vecs[i].rwid;
            read_addr    = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d read", i), read_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d valid", i), 128'(rt_req_valid), 128'(0));
            tick();
        end
        write_enable = 1'b0;

        // CMD to warp 2 with ready high, then completion
        wr(2, 4'hF, 3, 32'hCAFE0003);
        tick();
        wr(2, 4'hF, 8, 32'h0);
        rt_req_ready = 1'b1;
        rd_chk("cmd status pre", 2, 9, 128'h0);
        chk("cmd valid pre", 128'(rt_req_valid), 128'(0));
        tick();
        write_enable = 1'b0;
        req_chk("w2 req", 2, 4'hF);
        exp_rays = '0;
        for (int l = 0; l < NL; l++) exp_rays[(3*NL + l)*XL +: XL] = 32'hCAFE0003;
        exp_rays[(1*NL + 0)*XL +: XL] = 32'h0BAD0001;
        exp_rays[(1*NL + 1)*XL +: XL] = 32'h0BAD0001;
        chk_rays("w2 rays", exp_rays);
        rd_chk("w2 status pending", 2, 9, ONE4);
        tick();
        chk("w2 valid after accept", 128'(rt_req_valid), 128'(0));
        rd_chk("w2 status busy", 2, 9, ONE4);
        rt_req_ready = 1'b0;
        tick();
        tick();
        rd_chk("w2 status still busy", 2, 9, ONE4);
        rt_rsp_valid = 1'b1;
        rt_rsp_wid   = 2'd2;
        rd_chk("w2 status at rsp", 2, 9, ONE4);
        tick();
        rt_rsp_valid = 1'b0;
        rd_chk("w2 status done", 2, 9, 128'h0);

        // warps 0 and 3 back-to-back, ready held low: payload stays put
        do_reset();
        wr(0, 4'hF, 0, 32'h00000A00);
        tick();
        wr(3, 4'hF, 0, 32'h00000B00);
        tick();
        wr(0, 4'h3, 8, 32'h0);
        tick();
        wr(3, 4'hC, 8, 32'h0);
        exp_rays = '0;
        for (int l = 0; l < NL; l++) exp_rays[l*XL +: XL] = 32'h00000A00;
        for (int k = 0; k < 5; k++) begin
            req_chk($sformatf("hold%0d", k), 0, 4'h3);
            chk_rays($sformatf("hold%0d rays", k), exp_rays);
            tick();
            write_enable = 1'b0;
        end
        rt_req_ready = 1'b1;
        req_chk("grant0", 0, 4'h3);
        tick();
        req_chk("grant3", 3, 4'hC);
        exp_rays = '0;
        for (int l = 0; l < NL; l++) exp_rays[l*XL +: XL] = 32'h00000B00;
        chk_rays("grant3 rays", exp_rays);
        tick();
        rt_req_ready = 1'b0;
        chk("both granted valid", 128'(rt_req_valid), 128'(0));
        rd_chk("w0 busy", 0, 9, ONE4);
        rd_chk("w3 busy", 3, 9, ONE4);

        // writes to a BUSY warp are dropped; stray responses are ignored
        wr(1, 4'hF, 2, 32'h00000055);
        tick();
        wr(1, 4'hF, 8, 32'h0);
        rt_req_ready = 1'b1;
        tick();
        write_enable = 1'b0;
        req_chk("w1 req", 1, 4'hF);
        tick();
        rt_req_ready = 1'b0;
        wr(1, 4'hF, 2, 32'h00001234);
        rd_chk("busy write pre", 1, 2, all4(32'h55));
        tick();
        write_enable = 1'b0;
        rd_chk("busy write dropped", 1, 2, all4(32'h55));
        rt_rsp_valid = 1'b1;
        rt_rsp_wid   = 2'd0;
        tick();
        rt_rsp_valid = 1'b0;
        rd_chk("w0 done", 0, 9, 128'h0);
        rt_rsp_valid = 1'b1;
        tick();
        rt_rsp_valid = 1'b0;
        rd_chk("idle rsp w0", 0, 9, 128'h0);
        rd_chk("idle rsp w1 kept", 1, 9, ONE4);
        chk("idle rsp valid", 128'(rt_req_valid), 128'(0));
        wr(2, 4'hF, 8, 32'h0);
        tick();
        write_enable = 1'b0;
        rt_rsp_valid = 1'b1;
        rt_rsp_wid   = 2'd2;
        tick();
        rt_rsp_valid = 1'b0;
        rd_chk("pending rsp ignored", 2, 9, ONE4);
        req_chk("pending rsp req", 2, 4'hF);
        rt_req_ready = 1'b1;
        tick();
        rt_req_ready = 1'b0;
        chk("w2 accepted", 128'(rt_req_valid), 128'(0));

        // CMD and completion for BUSY warp 2 in the same cycle
        wr(2, 4'hF, 8, 32'h0);
        rt_rsp_valid = 1'b1;
        rt_rsp_wid   = 2'd2;
        tick();
        write_enable = 1'b0;
        rt_rsp_valid = 1'b0;
        rd_chk("race status", 2, 9, 128'h0);
        chk("race no req", 128'(rt_req_valid), 128'(0));
        tick();
        chk("race no req later", 128'(rt_req_valid), 128'(0));

        // round-robin rotation past the last winner
        rt_rsp_valid = 1'b1;
        rt_rsp_wid   = 2'd3;
        tick();
        rt_rsp_valid = 1'b0;
        rd_chk("w3 done", 3, 9, 128'h0);
        wr(0, 4'h1, 8, 32'h0);
        tick();
        wr(2, 4'h2, 8, 32'h0);
        tick();
        wr(3, 4'h4, 8, 32'h0);
        tick();
        write_enable = 1'b0;
        req_chk("rr first", 0, 4'h1);
        rt_req_ready = 1'b1;
        tick();
        req_chk("rr second", 2, 4'h2);
        tick();
        req_chk("rr third", 3, 4'h4);
        tick();
        rt_req_ready = 1'b0;
        chk("rr drained", 128'(rt_req_valid), 128'(0));

        // reset while warp 1 is BUSY
        rd_chk("pre-reset w1 busy", 1, 9, ONE4);
        do_reset();
        rd_chk("post-reset status", 1, 9, 128'h0);
        chk("post-reset valid", 128'(rt_req_valid), 128'(0));
        rd_chk("post-reset ray w1", 1, 2, 128'h0);
        rd_chk("post-reset ray w0", 0, 0, 128'h0);
        rt_rsp_valid = 1'b1;
        rt_rsp_wid   = 2'd1;
        tick();
        rt_rsp_valid = 1'b0;
        rd_chk("stale rsp status", 1, 9, 128'h0);
        chk("stale rsp valid", 128'(rt_req_valid), 128'(0));

        // report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
